nbank_spfifo: RTL and testbench

Synchronous single-clock FIFO built from `BANKS` interleaved single-port RAM banks, generalising the two-bank design to any power-of-two bank count. Sustains one push and one pop per cycle even though each bank allows only one access per cycle. Same-bank push/pop collisions are absorbed by a one-entry write stash. Adds threshold-based almost flags, an occupancy count, a synchronous clear, and a registered read path; sits between streaming producers and consumers inside datapath blocks.

---
 rtl/fifo_pkg.sv | 25 ++
 rtl/sp_bank.sv | 32 +++
 rtl/nbank_spfifo.sv | 217 +++++++++++++++++++++
 tb/tb_nbank_spfifo.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and pointer helpers for nbank_spfifo.
// Pointers are split into bank = low bits and row = next bits up.
package fifo_pkg;

  typedef struct packed {
    logic full;
    logic empty;
    logic al_full;
    logic al_empty;
  } fifo_status_t;

  // Bank index: the low bank_bits of a pointer.
  function automatic logic [31:0] bank_sel(input logic [31:0] ptr,
                                           input int unsigned bank_bits);
    return ptr & ((32'd1 << bank_bits) - 32'd1);
  endfunction

  // Row index: the row_bits directly above the bank bits.
  function automatic logic [31:0] row_sel(input logic [31:0] ptr,
                                          input int unsigned bank_bits,
                                          input int unsigned row_bits);
    return (ptr >> bank_bits) & ((32'd1 << row_bits) - 32'd1);
  endfunction

endpackage

// File: rtl/sp_bank.sv
// Single-port RAM bank: one access per cycle, registered read (1-cycle latency).
// The read register holds its value between reads.
module sp_bank #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Storage array write port (no reset on the array itself).
  always_ff @(posedge clk) begin
    if (en_i && we_i) mem_q[addr_i] <= wdata_i;
  end

  // Registered read data, updated only by a read access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              rdata_q <= '0;
    else if (en_i && !we_i)  rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/nbank_spfifo.sv
// nbank_spfifo: single-clock FIFO over BANKS interleaved single-port banks.
// One push and one pop per cycle; a same-bank push/pop collision parks the
// write in a one-entry stash that drains on the next cycle.
// Optional feature macro: NBANK_SPFIFO_ERR_EN (sticky ovf/udf outputs and a
// one-access-per-bank assertion).
module nbank_spfifo
  import fifo_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int SIZE     = 32,
  parameter int BANKS    = 2,
  parameter int AL_FULL  = 2,
  parameter int AL_EMPTY = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   valid,
  output logic                   ack,
  output logic                   full,
  output logic                   empty,
  output logic                   al_full,
  output logic                   al_empty,
  output logic [$clog2(SIZE):0]  count
`ifdef NBANK_SPFIFO_ERR_EN
  ,
  output logic                   ovf,
  output logic                   udf
`endif
);

  localparam int AW    = $clog2(SIZE);
  localparam int PW    = AW + 1;
  localparam int BB    = $clog2(BANKS);
  localparam int DEPTH = SIZE / BANKS;
  localparam int RB    = $clog2(DEPTH);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             stash_vld_q, stash_vld_d;
  logic [BB-1:0]    stash_bank_q, stash_bank_d;
  logic [RB-1:0]    stash_row_q, stash_row_d;
  logic [WIDTH-1:0] stash_data_q, stash_data_d;
  logic             valid_q, valid_d;
  logic [BB-1:0]    rd_bank_q, rd_bank_d;

  fifo_status_t     status;
  logic [PW-1:0]    cnt;
  logic             wen, ren, collide;
  logic [BB-1:0]    wbank, rbank;
  logic [RB-1:0]    wrow, rrow;

  logic [BANKS-1:0]            rd_req, wr_req, st_req;
  logic [BANKS-1:0][WIDTH-1:0] bank_rdata;

  assign cnt             = wr_ptr_q - rd_ptr_q;
  assign status.full     = (cnt == PW'(SIZE));
  assign status.empty    = (cnt == '0);
  assign status.al_full  = (cnt >= PW'(SIZE - AL_FULL));
  assign status.al_empty = (cnt <= PW'(AL_EMPTY));

  assign wen     = push & ~status.full  & ~clr;
  assign ren     = pop  & ~status.empty & ~clr;
  assign wbank   = BB'(bank_sel(32'(wr_ptr_q), BB));
  assign rbank   = BB'(bank_sel(32'(rd_ptr_q), BB));
  assign wrow    = RB'(row_sel(32'(wr_ptr_q), BB, RB));
  assign rrow    = RB'(row_sel(32'(rd_ptr_q), BB, RB));
  assign collide = wen & ren & (wbank == rbank);

  // Per-bank access demands; a collided write is diverted to the stash.
  always_comb begin
    rd_req = '0;
    wr_req = '0;
    st_req = '0;
    for (int unsigned b = 0; b < BANKS; b++) begin
      rd_req[b] = ren && (rbank == BB'(b));
      wr_req[b] = wen && !collide && (wbank == BB'(b));
      st_req[b] = stash_vld_q && !clr && (stash_bank_q == BB'(b));
    end
  end

  for (genvar g = 0; g < BANKS; g++) begin : g_bank
    logic             en, we;
    logic [RB-1:0]    addr;
    logic [WIDTH-1:0] wd;

    // Arbitration: read, then new write, then stash drain.
    always_comb begin
      en   = 1'b0;
      we   = 1'b0;
      addr = rrow;
      wd   = wdata;
      if (rd_req[g]) begin
        en   = 1'b1;
        addr = rrow;
      end else if (wr_req[g]) begin
        en   = 1'b1;
        we   = 1'b1;
        addr = wrow;
        wd   = wdata;
      end else if (st_req[g]) begin
        en   = 1'b1;
        we   = 1'b1;
        addr = stash_row_q;
        wd   = stash_data_q;
      end
    end

    sp_bank #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (en),
      .we_i    (we),
      .addr_i  (addr),
      .wdata_i (wd),
      .rdata_o (bank_rdata[g])
    );

`ifdef NBANK_SPFIFO_ERR_EN
    a_one_access: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0({rd_req[g], wr_req[g], st_req[g]}));
`endif
  end

  // Next-state for pointers, stash and read-valid tracking.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    stash_vld_d  = 1'b0;
    stash_bank_d = stash_bank_q;
    stash_row_d  = stash_row_q;
    stash_data_d = stash_data_q;
    valid_d      = ren;
    rd_bank_d    = rd_bank_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wen) wr_ptr_d = wr_ptr_q + PW'(1);
      if (ren) begin
        rd_ptr_d  = rd_ptr_q + PW'(1);
        rd_bank_d = rbank;
      end
      // The previous stash drains this cycle, so it can be reloaded at once.
      if (collide) begin
        stash_vld_d  = 1'b1;
        stash_bank_d = wbank;
        stash_row_d  = wrow;
        stash_data_d = wdata;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      stash_vld_q  <= 1'b0;
      stash_bank_q <= '0;
      stash_row_q  <= '0;
      stash_data_q <= '0;
      valid_q      <= 1'b0;
      rd_bank_q    <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      stash_vld_q  <= stash_vld_d;
      stash_bank_q <= stash_bank_d;
      stash_row_q  <= stash_row_d;
      stash_data_q <= stash_data_d;
      valid_q      <= valid_d;
      rd_bank_q    <= rd_bank_d;
    end
  end

`ifdef NBANK_SPFIFO_ERR_EN
  logic ovf_q, ovf_d, udf_q, udf_d;

  // Sticky overflow/underflow flags, cleared by clr.
  always_comb begin
    ovf_d = clr ? 1'b0 : (ovf_q | (push & status.full));
    udf_d = clr ? 1'b0 : (udf_q | (pop & status.empty));
  end

  // Error flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign ovf = ovf_q;
  assign udf = udf_q;
`endif

  // The last-read bank's output register holds while no new read occurs.
  assign rdata    = bank_rdata[rd_bank_q];
  assign valid    = valid_q;
  assign ack      = wen;
  assign full     = status.full;
  assign empty    = status.empty;
  assign al_full  = status.al_full;
  assign al_empty = status.al_empty;
  assign count    = cnt;

endmodule

// File: tb/tb_nbank_spfifo.sv
// Self-checking bench for nbank_spfifo (BANKS=4, SIZE=32) against a queue model.
module tb_nbank_spfifo;

  localparam int W  = 16;
  localparam int SZ = 32;
  localparam int NB = 4;
  localparam int AF = 2;
  localparam int AE = 2;
  localparam int CW = $clog2(SZ) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0, push = 1'b0, pop = 1'b0;
  logic [W-1:0]  wdata = '0;
  logic [W-1:0]  rdata;
  logic          valid, ack, full, empty, al_full, al_empty;
  logic [CW-1:0] count;
`ifdef NBANK_SPFIFO_ERR_EN
  logic          ovf, udf;
`endif

  nbank_spfifo #(
    .WIDTH    (W),
    .SIZE     (SZ),
    .BANKS    (NB),
    .AL_FULL  (AF),
    .AL_EMPTY (AE)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .push     (push),
    .wdata    (wdata),
    .pop      (pop),
    .rdata    (rdata),
    .valid    (valid),
    .ack      (ack),
    .full     (full),
    .empty    (empty),
    .al_full  (al_full),
    .al_empty (al_empty),
    .count    (count)
`ifdef NBANK_SPFIFO_ERR_EN
    ,
    .ovf      (ovf),
    .udf      (udf)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: contents in order, plus last popped value.
  logic [W-1:0] mq[$];
  logic         m_valid = 1'b0;
  logic [W-1:0] m_rdata = '0;
  logic         m_ack = 1'b0;
  logic         obs_ack = 1'b0;

  // One clock: drive inputs, sample ack mid-cycle, advance the model.
  task automatic step(input logic p, input logic [W-1:0] d, input logic q, input logic c);
    logic do_pop;
    push = p; wdata = d; pop = q; clr = c;
    m_ack  = p && !c && (mq.size() < SZ);
    do_pop = q && !c && (mq.size() > 0);
    @(negedge clk);
    obs_ack = ack;
    @(posedge clk);
    if (c) begin
      mq.delete();
      m_valid = 1'b0;
    end else begin
      if (do_pop) begin
        m_rdata = mq.pop_front();
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
      if (m_ack) mq.push_back(d);
    end
    #1;
    push = 1'b0; pop = 1'b0; clr = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    mq.delete(); m_valid = 1'b0; m_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (count !== '0)     begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
    n_cmp++; if (empty !== 1'b1)   begin n_err++; $display("FAIL reset_empty got %b want 1", empty); end
    n_cmp++; if (full !== 1'b0)    begin n_err++; $display("FAIL reset_full got %b want 0", full); end
    n_cmp++; if (al_empty !== 1'b1) begin n_err++; $display("FAIL reset_al_empty got %b want 1", al_empty); end
    n_cmp++; if (al_full !== 1'b0) begin n_err++; $display("FAIL reset_al_full got %b want 0", al_full); end
    n_cmp++; if (valid !== 1'b0)   begin n_err++; $display("FAIL reset_valid got %b want 0", valid); end
    n_cmp++; if (rdata !== '0)     begin n_err++; $display("FAIL reset_rdata got %h want 0", rdata); end
    n_cmp++; if (ack !== 1'b0)     begin n_err++; $display("FAIL reset_ack got %b want 0", ack); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill_drain;
    for (int i = 0; i < SZ; i++) begin
      step(1'b1, W'(i), 1'b0, 1'b0);
      n_cmp++; if (obs_ack !== 1'b1) begin n_err++; $display("FAIL fill_ack[%0d] got %b want 1", i, obs_ack); end
    end
    n_cmp++; if (full !== 1'b1)      begin n_err++; $display("FAIL fill_full got %b want 1", full); end
    n_cmp++; if (count !== CW'(SZ))  begin n_err++; $display("FAIL fill_count got %0d want %0d", count, SZ); end
    step(1'b1, 16'hDEAD, 1'b0, 1'b0);
    n_cmp++; if (obs_ack !== 1'b0)   begin n_err++; $display("FAIL over_ack got %b want 0", obs_ack); end
    n_cmp++; if (count !== CW'(SZ))  begin n_err++; $display("FAIL over_count got %0d want %0d", count, SZ); end
    for (int i = 0; i < SZ; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      n_cmp++; if (valid !== 1'b1)   begin n_err++; $display("FAIL drain_valid[%0d] got %b want 1", i, valid); end
      n_cmp++; if (rdata !== W'(i))  begin n_err++; $display("FAIL drain_data[%0d] got %h want %h", i, rdata, W'(i)); end
    end
    n_cmp++; if (empty !== 1'b1)     begin n_err++; $display("FAIL drain_empty got %b want 1", empty); end
    step(1'b0, '0, 1'b0, 1'b0);
    n_cmp++; if (valid !== 1'b0)     begin n_err++; $display("FAIL idle_valid got %b want 0", valid); end
    n_cmp++; if (rdata !== W'(SZ-1)) begin n_err++; $display("FAIL idle_hold got %h want %h", rdata, W'(SZ-1)); end
  endtask

  task automatic test_almost;
    for (int i = 0; i < 2*SZ; i++) begin
      if (i < SZ) step(1'b1, W'($urandom), 1'b0, 1'b0);
      else        step(1'b0, '0, 1'b1, 1'b0);
      n_cmp++; if (count !== CW'(mq.size()))
        begin n_err++; $display("FAIL almost_count got %0d want %0d", count, mq.size()); end
      n_cmp++; if (al_empty !== (mq.size() <= AE))
        begin n_err++; $display("FAIL al_empty@%0d got %b want %b", mq.size(), al_empty, mq.size() <= AE); end
      n_cmp++; if (al_full !== (mq.size() >= SZ - AF))
        begin n_err++; $display("FAIL al_full@%0d got %b want %b", mq.size(), al_full, mq.size() >= SZ - AF); end
      if (i >= SZ) begin
        n_cmp++; if (rdata !== m_rdata) begin n_err++; $display("FAIL almost_data got %h want %h", rdata, m_rdata); end
      end
    end
  endtask

  task automatic test_simul;
    for (int i = 0; i < SZ; i++) step(1'b1, W'($urandom), 1'b0, 1'b0);
    step(1'b1, 16'hBEEF, 1'b1, 1'b0);
    n_cmp++; if (obs_ack !== 1'b0)     begin n_err++; $display("FAIL full_pp_ack got %b want 0", obs_ack); end
    n_cmp++; if (count !== CW'(SZ-1))  begin n_err++; $display("FAIL full_pp_count got %0d want %0d", count, SZ-1); end
    n_cmp++; if (valid !== 1'b1)       begin n_err++; $display("FAIL full_pp_valid got %b want 1", valid); end
    n_cmp++; if (rdata !== m_rdata)    begin n_err++; $display("FAIL full_pp_data got %h want %h", rdata, m_rdata); end
    while (mq.size() > 0) begin
      step(1'b0, '0, 1'b1, 1'b0);
      n_cmp++; if (rdata !== m_rdata)  begin n_err++; $display("FAIL simul_drain got %h want %h", rdata, m_rdata); end
    end
    step(1'b1, 16'h1234, 1'b1, 1'b0);
    n_cmp++; if (obs_ack !== 1'b1)     begin n_err++; $display("FAIL empty_pp_ack got %b want 1", obs_ack); end
    n_cmp++; if (valid !== 1'b0)       begin n_err++; $display("FAIL empty_pp_valid got %b want 0", valid); end
    n_cmp++; if (count !== CW'(1))     begin n_err++; $display("FAIL empty_pp_count got %0d want 1", count); end
    step(1'b0, '0, 1'b1, 1'b0);
    n_cmp++; if (rdata !== 16'h1234 || valid !== 1'b1)
      begin n_err++; $display("FAIL empty_pp_data got %h/%b want 1234/1", rdata, valid); end
  endtask

  task automatic test_collisions;
    for (int i = 0; i < NB; i++) step(1'b1, W'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      step(1'b1, W'($urandom), 1'b1, 1'b0);
      n_cmp++; if (obs_ack !== 1'b1)   begin n_err++; $display("FAIL coll_ack[%0d] got %b want 1", i, obs_ack); end
      n_cmp++; if (count !== CW'(NB))  begin n_err++; $display("FAIL coll_count[%0d] got %0d want %0d", i, count, NB); end
      n_cmp++; if (valid !== 1'b1 || rdata !== m_rdata)
        begin n_err++; $display("FAIL coll_data[%0d] got %h/%b want %h/1", i, rdata, valid, m_rdata); end
    end
    for (int i = 0; i < NB; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      n_cmp++; if (rdata !== m_rdata)  begin n_err++; $display("FAIL coll_tail[%0d] got %h want %h", i, rdata, m_rdata); end
    end
  endtask

  task automatic test_clear_stash;
    logic [W-1:0] held;
    for (int i = 0; i < NB; i++) step(1'b1, W'($urandom), 1'b0, 1'b0);
    step(1'b1, 16'h5A5A, 1'b1, 1'b0);
    held = m_rdata;
    step(1'b1, 16'h7777, 1'b0, 1'b1);
    n_cmp++; if (count !== '0)     begin n_err++; $display("FAIL clr_count got %0d want 0", count); end
    n_cmp++; if (empty !== 1'b1)   begin n_err++; $display("FAIL clr_empty got %b want 1", empty); end
    n_cmp++; if (valid !== 1'b0)   begin n_err++; $display("FAIL clr_valid got %b want 0", valid); end
    n_cmp++; if (rdata !== held)   begin n_err++; $display("FAIL clr_hold got %h want %h", rdata, held); end
    for (int i = 0; i < 2*NB; i++) begin
      step(1'b1, W'(16'hA5 + i), 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      n_cmp++; if (valid !== 1'b1 || rdata !== W'(16'hA5 + i))
        begin n_err++; $display("FAIL clr_reuse[%0d] got %h/%b want %h/1", i, rdata, valid, W'(16'hA5 + i)); end
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 9) < 6), W'($urandom), ($urandom_range(0, 9) < 5), ($urandom_range(0, 99) < 3));
      n_cmp++; if (obs_ack !== m_ack)  begin n_err++; $display("FAIL rnd_ack[%0d] got %b want %b", i, obs_ack, m_ack); end
      n_cmp++; if (count !== CW'(mq.size()))
        begin n_err++; $display("FAIL rnd_count[%0d] got %0d want %0d", i, count, mq.size()); end
      n_cmp++; if ({full, empty} !== {mq.size() == SZ, mq.size() == 0})
        begin n_err++; $display("FAIL rnd_flags[%0d] got %b%b want %b%b", i, full, empty, mq.size() == SZ, mq.size() == 0); end
      n_cmp++; if ({al_full, al_empty} !== {mq.size() >= SZ - AF, mq.size() <= AE})
        begin n_err++; $display("FAIL rnd_almost[%0d] got %b%b want %b%b", i, al_full, al_empty, mq.size() >= SZ - AF, mq.size() <= AE); end
      n_cmp++; if (valid !== m_valid)  begin n_err++; $display("FAIL rnd_valid[%0d] got %b want %b", i, valid, m_valid); end
      n_cmp++; if (rdata !== m_rdata)  begin n_err++; $display("FAIL rnd_data[%0d] got %h want %h", i, rdata, m_rdata); end
    end
    step(1'b0, '0, 1'b0, 1'b1);
  endtask

`ifdef NBANK_SPFIFO_ERR_EN
  task automatic test_err;
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    n_cmp++; if (udf !== 1'b1) begin n_err++; $display("FAIL udf_set got %b want 1", udf); end
    step(1'b0, '0, 1'b0, 1'b0);
    n_cmp++; if (udf !== 1'b1) begin n_err++; $display("FAIL udf_hold got %b want 1", udf); end
    step(1'b0, '0, 1'b0, 1'b1);
    n_cmp++; if (udf !== 1'b0) begin n_err++; $display("FAIL udf_clr got %b want 0", udf); end
    for (int i = 0; i < SZ; i++) step(1'b1, W'(i), 1'b0, 1'b0);
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_early got %b want 0", ovf); end
    step(1'b1, '0, 1'b0, 1'b0);
    n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set got %b want 1", ovf); end
    step(1'b0, '0, 1'b0, 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_fill_drain();
    test_almost();
    test_simul();
    test_collisions();
    test_clear_stash();
    test_random();
`ifdef NBANK_SPFIFO_ERR_EN
    test_err();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
